shift_unit_mc: RTL and testbench
================================

# shift_unit_mc

Multi-cycle shift unit for the multicycle MIPS datapath: executes SRL and SRA (and optionally SLL) on a 32-bit operand by shifting one bit position per clock under a start/busy/done handshake. It complements the datapath's fixed left shifter by providing the right-shift direction with variable shift amounts. The ALU-stage controller drives it and stalls until `done`.

## Interface
- `WIDTH`, 32, operand and result width (fixed at 32 for MIPS).
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when not busy.
- `op`  in  2  00 SRL, 01 SRA, 10 SLL (only with macro), 11 reserved.
- `a`  in  32  operand; sampled with `start`.
- `shamt`  in  5  shift amount 0..31; sampled with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; `y` is valid from this cycle.
- `y`  out  32  result; holds until the next accepted `start`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Reset (any time, including mid-operation): state IDLE; `busy`=0, `done`=0, `y`=0, internal shift register and counter 0. An in-flight operation is discarded.
- IDLE or DONE with `start`=1: latch `a` into the shift register, `shamt` into the 5-bit down-counter, decode `op`; next state SHIFT.
- IDLE or DONE with `start`=0: DONE→IDLE; IDLE stays.
- SHIFT, counter≠0: shift register steps one bit; counter decrements.
  - SRL: `{0, r[31:1]}`.
  - SRA: `{r[31], r[31:1]}`.
  - SLL: `{r[30:0], 0}`.
- SHIFT, counter=0: `y` ← shift register; next state DONE.
- DONE: `done`=1 for exactly one cycle.
- `start` while in SHIFT is ignored: no latch, no queue.
- `op`=11 behaves as SRL. Without the macro, `op`=10 also behaves as SRL.
- `shamt`=0 passes `a` through unchanged after the minimum latency.
- Sign bit for SRA is taken from the latched `a[31]`; a later change on `a` has no effect.

## Timing
- `start` sampled high at edge E0. `busy`=1 from E0 through the edge that enters DONE.
- `done` and the new `y` appear after edge E0+`shamt`+1, i.e. latency `shamt`+2 cycles counting the start cycle. Range 2..33.
- `busy` is registered: 1 in SHIFT, 0 in IDLE and DONE.
- Back-to-back: `start` during the DONE cycle is accepted, with no idle bubble.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SHIFT_UNIT_SLL_EN` defined: `op`=10 performs a logical left shift with the same latency rules.
- Not defined: the SLL step logic is absent, and `op`=10 decodes as SRL.
- Ports are identical in both builds.

## Structure
- Package `shift_pkg` holds:
  - `typedef enum logic [1:0] shift_op_t` with `OP_SRL`, `OP_SRA`, `OP_SLL`, `OP_RSV`.
  - `typedef enum logic [1:0] shift_state_t` with `S_IDLE`, `S_SHIFT`, `S_DONE`.
  - `localparam SHAMT_W = 5`.
- Sub-module `shift_step`: purely combinational one-position shifter taking a 32-bit value and `shift_op_t` and producing the stepped value. Instantiated once in the datapath.

## Test plan
- Reset: drive `reset_n`=0 mid-SHIFT on a `shamt`=20 operation → immediately `busy`=0, `done`=0, `y`=0; no `done` pulse afterwards.
- SRL: `a`=0x8000_00F0, `shamt`=4 → `y`=0x0800_000F; `done` on the 6th cycle counting the start cycle.
- SRA: `a`=0x8000_00F0, `shamt`=31 → `y`=0xFFFF_FFFF with latency 33. Also `a`=0x7000_0000, `shamt`=28 → `y`=0x0000_0007.
- `shamt`=0, `op`=SRA, `a`=0xDEAD_BEEF → `y`=0xDEAD_BEEF; `done` 2 cycles after start.
- Handshake:
  - `start` pulsed during SHIFT with different `a` → ignored; the first result is unchanged.
  - `start` held high through DONE → the second operation is accepted with no idle cycle, and `done` pulses twice.
- Macro:
  - With `SHIFT_UNIT_SLL_EN`, `op`=10, `a`=0x0000_0003, `shamt`=30 → `y`=0xC000_0000.
  - Without the macro, the same stimulus → `y`=0x0000_0000 (SRL).

Source files
------------

// File: rtl/shift_unit_mc_pkg.sv
// Shared types and helpers for the multi-cycle shift unit.
// SHIFT_UNIT_SLL_EN enables decoding of op=10 as a logical left shift.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SRA = 2'b01,
        OP_SLL = 2'b10,
        OP_RSV = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } shift_state_t;

    localparam int unsigned SHAMT_W = 5;

    // Reserved codes (and SLL when the feature is off) collapse onto SRL at latch time.
    function automatic shift_op_t decode_op(input logic [1:0] raw);
        case (raw)
            2'b01: return OP_SRA;
`ifdef SHIFT_UNIT_SLL_EN
            2'b10: return OP_SLL;
`endif
            default: return OP_SRL;
        endcase
    endfunction

endpackage

// File: rtl/shift_unit_mc_step.sv
// One-position combinational shifter; the SLL path exists only with SHIFT_UNIT_SLL_EN.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  shift_op_t        op,
    output logic [WIDTH-1:0] stepped
);

    always_comb begin
        stepped = {1'b0, r[WIDTH-1:1]};
        case (op)
            OP_SRA: stepped = {r[WIDTH-1], r[WIDTH-1:1]};
`ifdef SHIFT_UNIT_SLL_EN
            OP_SLL: stepped = {r[WIDTH-2:0], 1'b0};
`endif
            default: stepped = {1'b0, r[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/shift_unit_mc.sv
// Multi-cycle SRL/SRA shifter (one bit per clock) with start/busy/done handshake.
// Define SHIFT_UNIT_SLL_EN to add logical left shift on op=10.
module shift_unit_mc
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   y
);

    shift_state_t       state_q, state_d;
    shift_op_t          op_q, op_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   sr_step;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .r       (sr_q),
        .op      (op_q),
        .stepped (sr_step)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sr_d    = a;
                    cnt_d   = shamt;
                    op_d    = decode_op(op);
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    sr_d  = sr_step;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    y_d     = sr_q;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_SRL;
            sr_q    <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign y    = y_q;

endmodule

// File: tb/tb_shift_unit_mc.sv
// Self-checking bench for shift_unit_mc; honours SHIFT_UNIT_SLL_EN like the design.
module tb_shift_unit_mc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] y;

    int n_vec = 0;
    int n_err = 0;

    shift_unit_mc #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .y       (y)
    );

    always #5 clk = ~clk;

    // Reference: whole-word shift by the requested amount.
    function automatic logic [31:0] model(input logic [31:0] av, input int s, input logic [1:0] o);
        logic signed [31:0] sa;
        sa = av;
        case (o)
            2'b01: return sa >>> s;
`ifdef SHIFT_UNIT_SLL_EN
            2'b10: return av << s;
`endif
            default: return av >> s;
        endcase
    endfunction

    // Counts edges after the accepting edge until done is seen (expected shamt+1).
    task automatic wait_done(output int edges, output bit busy_bad, output bit to,
                             output logic busy_at_done);
        edges = 0; busy_bad = 0; to = 1; busy_at_done = 1'bx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                to = 0;
                busy_at_done = busy;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1;
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic run_op(input logic [31:0] ai, input logic [4:0] si, input logic [1:0] oi,
                          output logic [31:0] yo, output int edges, output bit busy_bad,
                          output bit to, output logic busy_at_done);
        @(negedge clk);
        start = 1'b1; a = ai; shamt = si; op = oi;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; shamt = 5'($urandom); op = 2'($urandom);
        wait_done(edges, busy_bad, to, busy_at_done);
        yo = y;
    endtask

    task automatic check_op(input string name, input logic [31:0] ai, input logic [4:0] si,
                            input logic [1:0] oi);
        logic [31:0] yo, exp;
        int edges;
        bit bb, to;
        logic bd;
        exp = model(ai, int'(si), oi);
        run_op(ai, si, oi, yo, edges, bb, to, bd);
        n_vec++;
        if (to) begin
            n_err++; $display("FAIL %s timeout: done never seen", name);
        end else begin
            if (yo !== exp) begin
                n_err++; $display("FAIL %s y: got %h expected %h", name, yo, exp);
            end
            n_vec++;
            if (edges !== int'(si) + 1) begin
                n_err++; $display("FAIL %s latency: got %0d edges expected %0d", name, edges, int'(si) + 1);
            end
            n_vec++;
            if (bb || bd !== 1'b0) begin
                n_err++; $display("FAIL %s busy: bad_in_shift=%0d busy_at_done=%b expected 0/0", name, bb, bd);
            end
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0 || y !== exp) begin
                n_err++;
                $display("FAIL %s after_done: done=%b busy=%b y=%h expected 0 0 %h", name, done, busy, y, exp);
            end
        end
    endtask

    task automatic test_reset();
        int edges;
        bit seen;
        reset_n = 1'b0; start = 1'b0; op = '0; a = '0; shamt = '0;
        #3;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== 32'h0) begin
            n_err++; $display("FAIL reset_init: busy=%b done=%b y=%h expected 0 0 0", busy, done, y);
        end
        @(negedge clk); reset_n = 1'b1;
        check_op("reset_pre", 32'h1234_5678, 5'd3, 2'b00);
        @(negedge clk);
        start = 1'b1; a = 32'hF0F0_1234; shamt = 5'd20; op = 2'b01;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL reset_midop_busy: got %b expected 1", busy);
        end
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== 32'h0) begin
            n_err++; $display("FAIL reset_midop: busy=%b done=%b y=%h expected 0 0 0", busy, done, y);
        end
        @(negedge clk); reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        n_vec++;
        if (seen) begin
            n_err++; $display("FAIL reset_no_done: activity after reset, expected none");
        end
        edges = 0;
    endtask

    task automatic test_directed();
        check_op("srl_4",       32'h8000_00F0, 5'd4,  2'b00);
        check_op("sra_31",      32'h8000_00F0, 5'd31, 2'b01);
        check_op("sra_28",      32'h7000_0000, 5'd28, 2'b01);
        check_op("sra_0",       32'hDEAD_BEEF, 5'd0,  2'b01);
        check_op("rsv_as_srl",  32'hFFFF_0000, 5'd8,  2'b11);
        check_op("op10",        32'h0000_0003, 5'd30, 2'b10);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            check_op("random", $urandom, 5'($urandom), 2'($urandom));
    endtask

    task automatic test_start_ignored();
        logic [31:0] exp;
        int edges;
        bit bb, to;
        logic bd;
        exp = model(32'hA5A5_0F0F, 12, 2'b01);
        @(negedge clk);
        start = 1'b1; a = 32'hA5A5_0F0F; shamt = 5'd12; op = 2'b01;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1; start = 1'b1; a = 32'h0000_FFFF; shamt = 5'd3; op = 2'b00;
        @(posedge clk); #1; start = 1'b0;
        wait_done(edges, bb, to, bd);
        n_vec++;
        if (to || y !== exp || edges !== 9) begin
            n_err++; $display("FAIL start_ignored: to=%0d y=%h edges=%0d expected y=%h edges=9", to, y, edges, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp1, exp2;
        int edges;
        bit bb, to;
        logic bd;
        exp1 = model(32'h8765_4321, 6, 2'b00);
        exp2 = model(32'hC000_0001, 9, 2'b01);
        @(negedge clk);
        start = 1'b1; a = 32'h8765_4321; shamt = 5'd6; op = 2'b00;
        @(posedge clk); #1; a = $urandom; shamt = 5'($urandom);
        wait_done(edges, bb, to, bd);
        n_vec++;
        if (to || y !== exp1 || edges !== 7) begin
            n_err++; $display("FAIL b2b_first: to=%0d y=%h edges=%0d expected y=%h edges=7", to, y, edges, exp1);
        end
        a = 32'hC000_0001; shamt = 5'd9; op = 2'b01;
        @(posedge clk); #1; start = 1'b0;
        wait_done(edges, bb, to, bd);
        n_vec++;
        if (to || y !== exp2 || edges !== 10 || bb) begin
            n_err++;
            $display("FAIL b2b_second: to=%0d y=%h edges=%0d busy_gap=%0d expected y=%h edges=10 no gap",
                     to, y, edges, bb, exp2);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
